// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard sequencer (slave) and the datapath (master).
// Signal suffixes are from the sequencer's point of view.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs_i;
  logic [4:0]       id_rt_i;
  logic             id_uses_rt_i;
  logic             ex_mem_read_i;
  logic [4:0]       ex_num_write_i;
  logic             branch_taken_i;
  logic             mem_access_i;
  logic             dmem_ready_i;
  logic             pc_en_o;
  logic             if_id_en_o;
  logic             id_ex_en_o;
  logic             ex_mem_en_o;
  logic             if_id_flush_o;
  logic             id_ex_flush_o;
  logic             mem_wb_bubble_o;
  logic             dmem_req_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cycles_o;

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_num_write_i,
           branch_taken_i, mem_access_i, dmem_ready_i,
    output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, if_id_flush_o,
           id_ex_flush_o, mem_wb_bubble_o, dmem_req_o, mem_err_o, stall_cycles_o
  );

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_num_write_i,
           branch_taken_i, mem_access_i, dmem_ready_i,
    input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, if_id_flush_o,
           id_ex_flush_o, mem_wb_bubble_o, dmem_req_o, mem_err_o, stall_cycles_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, branch squashes,
// multi-cycle data-memory waits with timeout, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q;

  logic lu_hazard_s;
  logic pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s;
  logic if_id_flush_s, id_ex_flush_s, mem_wb_bubble_s, dmem_req_s;

  // Load-use detection against the instruction currently in ID
  always_comb begin
    lu_hazard_s = bus.ex_mem_read_i && (bus.ex_num_write_i != 5'd0) &&
                  ((bus.ex_num_write_i == bus.id_rs_i) ||
                   (bus.id_uses_rt_i && (bus.ex_num_write_i == bus.id_rt_i)));
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    mem_err_d       = mem_err_q;
    pc_en_s         = 1'b0;
    if_id_en_s      = 1'b0;
    id_ex_en_s      = 1'b0;
    ex_mem_en_s     = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    mem_wb_bubble_s = 1'b1;
    dmem_req_s      = 1'b0;

    // pipe_go: memory side is not stalling, so apply branch > load-use > normal
    case (state_q)
      RUN: begin
        dmem_req_s = bus.mem_access_i;
        if (bus.mem_access_i && !bus.dmem_ready_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          mem_wb_bubble_s = 1'b0;
          pipe_go();
        end
      end
      MEM_WAIT: begin
        dmem_req_s = 1'b1;
        if (bus.dmem_ready_i) begin
          mem_wb_bubble_s = 1'b0;
          state_d         = RUN;
          wait_cnt_d      = 8'd0;
          pipe_go();
        end else if (wait_cnt_q < 8'(MEM_TIMEOUT)) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
          // Abandon: release the pipeline but keep the write suppressed
          dmem_req_s  = 1'b0;
          pc_en_s     = 1'b1;
          if_id_en_s  = 1'b1;
          id_ex_en_s  = 1'b1;
          ex_mem_en_s = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = RUN;
          wait_cnt_d  = 8'd0;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  function automatic void pipe_go();
    if (bus.branch_taken_i) begin
      pc_en_s       = 1'b1;
      if_id_en_s    = 1'b1;
      id_ex_en_s    = 1'b1;
      ex_mem_en_s   = 1'b1;
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (lu_hazard_s) begin
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_en_s    = 1'b1;
      id_ex_flush_s = 1'b1;
      ex_mem_en_s   = 1'b1;
    end else begin
      pc_en_s     = 1'b1;
      if_id_en_s  = 1'b1;
      id_ex_en_s  = 1'b1;
      ex_mem_en_s = 1'b1;
    end
  endfunction

  // State, timeout counter, sticky error and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      mem_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
      if (!pc_en_s && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_q <= stall_q;
      end
    end
  end

  // Reset forces the safe control pattern independent of state
  assign bus.pc_en_o         = rst_n ? pc_en_s         : 1'b0;
  assign bus.if_id_en_o      = rst_n ? if_id_en_s      : 1'b0;
  assign bus.id_ex_en_o      = rst_n ? id_ex_en_s      : 1'b0;
  assign bus.ex_mem_en_o     = rst_n ? ex_mem_en_s     : 1'b0;
  assign bus.if_id_flush_o   = rst_n ? if_id_flush_s   : 1'b0;
  assign bus.id_ex_flush_o   = rst_n ? id_ex_flush_s   : 1'b0;
  assign bus.mem_wb_bubble_o = rst_n ? mem_wb_bubble_s : 1'b1;
  assign bus.dmem_req_o      = rst_n ? dmem_req_s      : 1'b0;
  assign bus.mem_err_o       = mem_err_q;
  assign bus.stall_cycles_o  = stall_q;

endmodule
